// File: rtl/wb_load_unit.sv
// Writeback stage: forwards ALU results to the register file and runs single-outstanding
// loads (request, wait, extract/extend) through the register file's only write port.
module wb_load_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_result,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  load_err,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [2:0]            r_funct3;
  logic [1:0]            r_off;
  logic                  r_wen;
  logic [DATA_WIDTH-1:0] r_addr;
  logic                  r_rf_wen;
  logic [ADDR_WIDTH-1:0] r_rf_waddr;
  logic [DATA_WIDTH-1:0] r_rf_wdata;
  logic                  r_load_err;

  logic                  w_accept;
  logic                  w_legal;
  logic                  w_aligned;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_data;

  assign w_accept = in_valid && (r_state == S_IDLE);

  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b0;
    case (in_funct3)
      3'b000, 3'b100: begin w_legal = 1'b1; w_aligned = 1'b1; end
      3'b001, 3'b101: begin w_legal = 1'b1; w_aligned = ~in_result[0]; end
      3'b010:         begin w_legal = 1'b1; w_aligned = (in_result[1:0] == 2'b00); end
      default:        begin w_legal = 1'b0; w_aligned = 1'b0; end
    endcase
  end

  // funct3[2] selects zero extension, funct3[1:0] the access size.
  always_comb begin
    w_byte      = mem_rdata[{r_off, 3'b000} +: 8];
    w_half      = mem_rdata[{r_off[1], 4'b0000} +: 16];
    w_load_data = mem_rdata;
    case (r_funct3[1:0])
      2'b00:   w_load_data = {{(DATA_WIDTH-8){w_byte[7] & ~r_funct3[2]}}, w_byte};
      2'b01:   w_load_data = {{(DATA_WIDTH-16){w_half[15] & ~r_funct3[2]}}, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rd       <= '0;
      r_funct3   <= '0;
      r_off      <= '0;
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_rf_wen   <= 1'b0;
      r_load_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!in_is_load) begin
              r_rf_wen   <= in_wen && (in_rd != '0);
              r_rf_waddr <= in_rd;
              r_rf_wdata <= in_result;
            end else if (!(w_legal && w_aligned)) begin
              r_load_err <= 1'b1;
            end else begin
              r_rd     <= in_rd;
              r_funct3 <= in_funct3;
              r_off    <= in_result[1:0];
              r_wen    <= in_wen;
              r_addr   <= {in_result[DATA_WIDTH-1:2], 2'b00};
              r_state  <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            r_rf_wen   <= r_wen && (r_rd != '0);
            r_rf_waddr <= r_rd;
            r_rf_wdata <= w_load_data;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_req_addr  = r_addr;
  assign rf_wen        = r_rf_wen;
  assign rf_waddr      = r_rf_waddr;
  assign rf_wdata      = r_rf_wdata;
  assign load_err      = r_load_err;

endmodule

// File: tb/tb_wb_load_unit.sv
// Directed bench for wb_load_unit: reset, ALU forwarding, load extension,
// handshake stalls, load errors and reset in the middle of a load.
module tb_wb_load_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [31:0] in_result;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  wb_load_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_wen(in_wen),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .in_result(in_result),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic ld, input logic [4:0] rd, input logic wen,
                          input logic [2:0] f3, input logic [31:0] res);
    in_valid   = 1'b1;
    in_is_load = ld;
    in_rd      = rd;
    in_wen     = wen;
    in_funct3  = f3;
    in_result  = res;
  endtask

  task automatic do_load(input string tag, input logic [4:0] rd, input logic wen,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                         input int req_stall, input int resp_delay,
                         input logic exp_wen, input logic [31:0] exp_data);
    int pulses;
    drive_in(1'b1, rd, wen, f3, addr);
    tick();
    in_valid = 1'b0;
    check({tag, ".req_valid"}, {31'd0, mem_req_valid}, 32'd1);
    check({tag, ".req_addr"}, mem_req_addr, {addr[31:2], 2'b00});
    for (int i = 0; i < req_stall; i++) begin
      tick();
      check({tag, ".stall_addr"}, mem_req_addr, {addr[31:2], 2'b00});
      check({tag, ".stall_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check({tag, ".wait_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
    pulses = 0;
    for (int i = 0; i < resp_delay; i++) begin
      tick();
      if (rf_wen) pulses++;
    end
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    tick();
    mem_resp_valid = 1'b0;
    if (rf_wen) pulses++;
    check({tag, ".rf_wen"}, {31'd0, rf_wen}, {31'd0, exp_wen});
    if (exp_wen) begin
      check({tag, ".rf_waddr"}, {27'd0, rf_waddr}, {27'd0, rd});
      check({tag, ".rf_wdata"}, rf_wdata, exp_data);
    end
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    if (rf_wen) pulses++;
    check({tag, ".wen_pulses"}, pulses, exp_wen ? 32'd1 : 32'd0);
  endtask

  task automatic bad_load(input string tag, input logic [2:0] f3, input logic [31:0] addr);
    drive_in(1'b1, 5'd3, 1'b1, f3, addr);
    tick();
    in_valid = 1'b0;
    check({tag, ".load_err"}, {31'd0, load_err}, 32'd1);
    check({tag, ".req_valid"}, {31'd0, mem_req_valid}, 32'd0);
    check({tag, ".rf_wen"}, {31'd0, rf_wen}, 32'd0);
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    check({tag, ".err_clear"}, {31'd0, load_err}, 32'd0);
    check({tag, ".req_after"}, {31'd0, mem_req_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_wen = 1'b0; in_is_load = 1'b0;
    in_funct3 = '0; in_result = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.outs", {27'd0, mem_req_valid, rf_wen, load_err, busy, 1'b0}, 32'd0);
    check("rst.addr", mem_req_addr, 32'd0);
    check("rst.wdata", rf_wdata, 32'd0);
    check("rst.waddr", {27'd0, rf_waddr}, 32'd0);
    rst_n = 1'b1;
    tick();

    drive_in(1'b0, 5'd5, 1'b1, 3'b000, 32'h1234_5678);
    tick();
    in_valid = 1'b0;
    check("alu.wen", {31'd0, rf_wen}, 32'd1);
    check("alu.waddr", {27'd0, rf_waddr}, 32'd5);
    check("alu.wdata", rf_wdata, 32'h1234_5678);
    tick();
    check("alu.wen_off", {31'd0, rf_wen}, 32'd0);

    drive_in(1'b0, 5'd1, 1'b1, 3'b000, 32'hA);
    tick();
    check("b2b1.wen", {31'd0, rf_wen}, 32'd1);
    check("b2b1.waddr", {27'd0, rf_waddr}, 32'd1);
    check("b2b1.wdata", rf_wdata, 32'hA);
    drive_in(1'b0, 5'd0, 1'b1, 3'b000, 32'hB);
    tick();
    check("b2b2.wen_x0", {31'd0, rf_wen}, 32'd0);
    drive_in(1'b0, 5'd2, 1'b1, 3'b000, 32'hC);
    tick();
    in_valid = 1'b0;
    check("b2b3.wen", {31'd0, rf_wen}, 32'd1);
    check("b2b3.waddr", {27'd0, rf_waddr}, 32'd2);
    check("b2b3.wdata", rf_wdata, 32'hC);
    tick();
    check("b2b.idle_wen", {31'd0, rf_wen}, 32'd0);

    do_load("lb",  5'd6,  1'b1, 3'b000, 32'h103, 32'h80F0_7F81, 0, 0, 1'b1, 32'hFFFF_FF80);
    do_load("lbu", 5'd7,  1'b1, 3'b100, 32'h100, 32'h80F0_7F81, 0, 0, 1'b1, 32'h0000_0081);
    do_load("lh",  5'd8,  1'b1, 3'b001, 32'h102, 32'h80F0_7F81, 0, 0, 1'b1, 32'hFFFF_80F0);
    do_load("lhu", 5'd9,  1'b1, 3'b101, 32'h100, 32'h80F0_7F81, 0, 0, 1'b1, 32'h0000_7F81);
    do_load("lw",  5'd10, 1'b1, 3'b010, 32'h100, 32'h80F0_7F81, 0, 0, 1'b1, 32'h80F0_7F81);
    do_load("lbu1", 5'd11, 1'b1, 3'b100, 32'h201, 32'h1234_A5C3, 0, 0, 1'b1, 32'h0000_00A5);
    do_load("stall", 5'd12, 1'b1, 3'b010, 32'h2000_0044, 32'hDEAD_BEEF, 4, 5, 1'b1, 32'hDEAD_BEEF);
    do_load("ld_x0",   5'd0,  1'b1, 3'b010, 32'h300, 32'h1111_1111, 1, 1, 1'b0, 32'h0);
    do_load("ld_nowen", 5'd13, 1'b0, 3'b010, 32'h300, 32'h2222_2222, 0, 0, 1'b0, 32'h0);

    bad_load("err_lw",   3'b010, 32'h102);
    bad_load("err_f3",   3'b011, 32'h100);
    bad_load("err_lh",   3'b001, 32'h101);

    drive_in(1'b1, 5'd14, 1'b1, 3'b010, 32'h400);
    tick();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("rstmid.busy_wait", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstmid.in_ready", {31'd0, in_ready}, 32'd1);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h5555_5555;
    tick();
    mem_resp_valid = 1'b0;
    check("rstmid.rf_wen", {31'd0, rf_wen}, 32'd0);
    check("rstmid.busy", {31'd0, busy}, 32'd0);
    check("rstmid.in_ready2", {31'd0, in_ready}, 32'd1);
    tick();
    check("rstmid.rf_wen2", {31'd0, rf_wen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
